ahb_regbank: RTL and testbench

Parametrised AHB-Lite slave register bank: NUM_REGS 32-bit read/write registers with byte/halfword/word writes, zero-wait-state OKAY transfers and a two-cycle ERROR response for illegal accesses. It sits on the AHB-Lite slave mux as a drop-in peripheral. Register contents are exported as a flat vector to the IP core, with per-register write pulses.

---
 rtl/ahb_regbank_pkg.sv | 24 ++
 rtl/ahb_regbank_lanes.sv | 29 ++
 rtl/ahb_regbank.sv | 139 +++++++++++++
 tb/tb_ahb_regbank.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_regbank_pkg.sv
// rtl/ahb_regbank_pkg.sv - shared AHB-Lite encodings and FSM state type for ahb_regbank
package ahb_regbank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_regbank_lanes.sv
// rtl/ahb_regbank_lanes.sv - byte-lane strobe and alignment/size error decode
module ahb_regbank_lanes
  import ahb_regbank_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       align_err
);

  always_comb begin
    strb      = 4'b0000;
    align_err = 1'b0;
    case (hsize)
      HSIZE_BYTE: strb = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        align_err = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb      = 4'b1111;
        align_err = |addr_lo;
      end
      // Anything wider than a word cannot map onto a 32-bit register.
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_regbank.sv
// rtl/ahb_regbank.sv - AHB-Lite slave register bank with byte/half/word writes
// Two-cycle ERROR response on illegal accesses only when AHB_REGBANK_ERR_EN is defined.
module ahb_regbank
  import ahb_regbank_pkg::*;
#(
  parameter int          NUM_REGS  = 8,
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [1:0]              HTRANS,
  input  logic [2:0]              HSIZE,
  input  logic                    HWRITE,
  input  logic [31:0]             HADDR,
  input  logic [31:0]             HWDATA,
  output logic                    HREADYOUT,
  output logic [1:0]              HRESP,
  output logic [31:0]             HRDATA,
  output logic [32*NUM_REGS-1:0]  reg_q,
  output logic [NUM_REGS-1:0]     reg_wr
);

  localparam int IDX_W = ADDR_W - 2;

  logic              valid;
  logic              legal;
  logic [IDX_W-1:0]  addr_idx;
  logic [3:0]        strb;
  logic              align_err;
  logic              unused_haddr;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic [3:0]        strb_q;
  logic [31:0]       regs [NUM_REGS];

  assign valid        = HSEL & HREADY & ((HTRANS == HTRANS_NONSEQ) | (HTRANS == HTRANS_SEQ));
  assign addr_idx     = HADDR[ADDR_W-1:2];
  assign legal        = ~align_err & (32'(addr_idx) < 32'(NUM_REGS));
  assign unused_haddr = &{1'b0, HADDR[31:ADDR_W]};

  ahb_regbank_lanes u_lanes (
    .hsize     (HSIZE),
    .addr_lo   (HADDR[1:0]),
    .strb      (strb),
    .align_err (align_err)
  );

`ifdef AHB_REGBANK_ERR_EN
  logic       hreadyout_q;
  logic [1:0] hresp_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      idx_q       <= '0;
      strb_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else if (state == ST_ERR1) begin
      // HREADY is low during ERR1, so no address phase can be taken here.
      state       <= ST_ERR2;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_ERROR;
    end else if (valid && legal) begin
      state       <= HWRITE ? ST_WRITE : ST_READ;
      idx_q       <= addr_idx;
      strb_q      <= strb;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else if (valid) begin
      state       <= ST_ERR1;
      hreadyout_q <= 1'b0;
      hresp_q     <= HRESP_ERROR;
    end else begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
`else
  // Illegal accesses fall back to IDLE: the data phase completes OKAY with no effect.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= ST_IDLE;
      idx_q  <= '0;
      strb_q <= '0;
    end else if (valid && legal) begin
      state  <= HWRITE ? ST_WRITE : ST_READ;
      idx_q  <= addr_idx;
      strb_q <= strb;
    end else begin
      state  <= ST_IDLE;
    end
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = HRESP_OKAY;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      reg_wr <= '0;
    end else begin
      reg_wr <= '0;
      if (state == ST_WRITE) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            reg_wr[i] <= 1'b1;
            for (int b = 0; b < 4; b++) begin
              if (strb_q[b]) regs[i][8*b +: 8] <= HWDATA[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    HRDATA = 32'h0;
    if (state == ST_READ) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (idx_q == IDX_W'(i)) HRDATA = regs[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
    assign reg_q[32*g +: 32] = regs[g];
  end

endmodule

// File: tb/tb_ahb_regbank.sv
// tb/tb_ahb_regbank.sv - self-checking bench for ahb_regbank (NUM_REGS=8, ADDR_W=12)
module tb_ahb_regbank;

`ifdef AHB_REGBANK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         HCLK, HRESETn, HSEL, HREADY, HWRITE, hready_ovr;
  logic [1:0]   HTRANS, HRESP;
  logic [2:0]   HSIZE;
  logic [31:0]  HADDR, HWDATA, HRDATA;
  logic         HREADYOUT;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr;

  logic [31:0]  model [8];
  int           exp_pulses [8];
  int           pulse_cnt [8];
  int           n_checks = 0;
  int           n_fail = 0;

  assign HREADY = hready_ovr & HREADYOUT;

  ahb_regbank #(.NUM_REGS(8), .ADDR_W(12), .RESET_VAL(32'h0)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .reg_q(reg_q), .reg_wr(reg_wr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    for (int i = 0; i < 8; i++) if (reg_wr[i]) pulse_cnt[i]++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_legal(input logic [31:0] addr, input int size);
    int a, off;
    a   = int'(addr % 4096);
    off = a % 4;
    if (a / 4 >= 8) return 1'b0;
    if (size > 2) return 1'b0;
    if (size == 1 && (off % 2) != 0) return 1'b0;
    if (size == 2 && off != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [31:0] addr, input int size);
    logic [31:0] mask;
    int off;
    off = int'(addr % 4);
    if (size == 0)      mask = 32'hFF << (8 * off);
    else if (size == 1) mask = 32'hFFFF << (8 * off);
    else                mask = 32'hFFFF_FFFF;
    return (old & ~mask) | (wdata & mask);
  endfunction

  function automatic logic [255:0] m_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  // Applies one transfer to the reference model and returns the data the bus should see.
  function automatic logic [31:0] m_apply(input bit wr, input logic [31:0] addr,
                                          input int size, input logic [31:0] wdata);
    int idx;
    idx = int'(addr % 4096) / 4;
    if (!m_legal(addr, size)) return 32'h0;
    if (wr) begin
      model[idx] = m_merge(model[idx], wdata, addr, size);
      exp_pulses[idx]++;
      return 32'h0;
    end
    return model[idx];
  endfunction

  // Entry and exit: 1 time unit after a rising edge, bus idle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata, output int waits,
                      output logic [1:0] resp_first, output logic [1:0] resp_last);
    bit done;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr; HSIZE = size;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
    waits = 0; done = 1'b0; rdata = 32'h0; resp_first = 2'bxx; resp_last = 2'bxx;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge HCLK);
      if (c == 0) resp_first = HRESP;
      if (HREADYOUT) begin
        rdata = HRDATA; resp_last = HRESP; done = 1'b1;
      end else begin
        waits++;
        @(posedge HCLK); #1;
      end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
    n_checks++; if (HRESP !== 2'b00) begin n_fail++; $display("FAIL reset_hresp got=%b exp=00", HRESP); end
    n_checks++; if (HRDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
    n_checks++; if (reg_q !== 256'h0) begin n_fail++; $display("FAIL reset_reg_q got=%h exp=0", reg_q); end
    n_checks++; if (reg_wr !== 8'h0) begin n_fail++; $display("FAIL reset_reg_wr got=%b exp=0", reg_wr); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_rd;
    void'(m_apply(1'b1, 32'h008, 2, 32'hDEAD_BEEF));
    exp_rd = m_apply(1'b0, 32'h008, 2, 32'h0);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h008; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HTRANS = 2'b11; HWRITE = 1'b0; HWDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin n_fail++; $display("FAIL b2b_write_phase got=%b/%b exp=1/00", HREADYOUT, HRESP); end
    n_checks++; if (reg_wr !== 8'h00) begin n_fail++; $display("FAIL b2b_early_pulse got=%b exp=00000000", reg_wr); end
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    n_checks++; if (HRDATA !== exp_rd) begin n_fail++; $display("FAIL b2b_read_data got=%h exp=%h", HRDATA, exp_rd); end
    n_checks++; if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin n_fail++; $display("FAIL b2b_read_phase got=%b/%b exp=1/00", HREADYOUT, HRESP); end
    n_checks++; if (reg_wr !== 8'b0000_0100) begin n_fail++; $display("FAIL b2b_pulse got=%b exp=00000100", reg_wr); end
    n_checks++; if (reg_q !== m_flat()) begin n_fail++; $display("FAIL b2b_reg_q got=%h exp=%h", reg_q, m_flat()); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_checks++; if (reg_wr !== 8'h00) begin n_fail++; $display("FAIL b2b_pulse_width got=%b exp=00000000", reg_wr); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_lanes();
    logic [31:0] rd, wd, exp;
    logic [1:0]  rf, rl;
    int          w;
    xfer(1'b1, 32'h00C, 3'b010, 32'h1122_3344, rd, w, rf, rl);
    void'(m_apply(1'b1, 32'h00C, 2, 32'h1122_3344));
    wd = $urandom; wd[15:8] = 8'hAA;
    xfer(1'b1, 32'h00D, 3'b000, wd, rd, w, rf, rl);
    void'(m_apply(1'b1, 32'h00D, 0, wd));
    n_checks++; if (reg_q[127:96] !== 32'h1122_AA44) begin n_fail++; $display("FAIL lanes_byte got=%h exp=1122aa44", reg_q[127:96]); end
    wd = $urandom; wd[31:16] = 16'h5566;
    xfer(1'b1, 32'h00E, 3'b001, wd, rd, w, rf, rl);
    void'(m_apply(1'b1, 32'h00E, 1, wd));
    n_checks++; if (reg_q[127:96] !== 32'h5566_AA44) begin n_fail++; $display("FAIL lanes_half got=%h exp=5566aa44", reg_q[127:96]); end
    exp = m_apply(1'b0, 32'h00C, 2, 32'h0);
    xfer(1'b0, 32'h00C, 3'b010, 32'h0, rd, w, rf, rl);
    n_checks++; if (rd !== exp || w !== 0) begin n_fail++; $display("FAIL lanes_readback got=%h/%0d exp=%h/0", rd, w, exp); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic [1:0]  rf, rl, exp_resp;
    int          w, exp_w;
    exp_w    = ERR_EN ? 1 : 0;
    exp_resp = ERR_EN ? 2'b01 : 2'b00;
    xfer(1'b0, 32'h020, 3'b010, 32'h0, rd, w, rf, rl);
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL err_rd_waits got=%0d exp=%0d", w, exp_w); end
    n_checks++; if (rf !== exp_resp || rl !== exp_resp) begin n_fail++; $display("FAIL err_rd_resp got=%b/%b exp=%b/%b", rf, rl, exp_resp, exp_resp); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_rd_data got=%h exp=0", rd); end
    n_checks++; if (reg_q !== m_flat()) begin n_fail++; $display("FAIL err_rd_regs got=%h exp=%h", reg_q, m_flat()); end
    xfer(1'b1, 32'h001, 3'b001, 32'hFFFF_FFFF, rd, w, rf, rl);
    n_checks++; if (w !== exp_w) begin n_fail++; $display("FAIL err_wr_waits got=%0d exp=%0d", w, exp_w); end
    n_checks++; if (rf !== exp_resp || rl !== exp_resp) begin n_fail++; $display("FAIL err_wr_resp got=%b/%b exp=%b/%b", rf, rl, exp_resp, exp_resp); end
    n_checks++; if (reg_q !== m_flat()) begin n_fail++; $display("FAIL err_wr_regs got=%h exp=%h", reg_q, m_flat()); end
  endtask

  task automatic test_ignored();
    logic [1:0] trans [3];
    bit         ovr [3];
    trans[0] = 2'b00; ovr[0] = 1'b1;
    trans[1] = 2'b01; ovr[1] = 1'b1;
    trans[2] = 2'b10; ovr[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      HSEL = 1'b1; HTRANS = trans[k]; hready_ovr = ovr[k]; HWRITE = 1'b1;
      HSIZE = 3'b010; HADDR = 32'(4 * k);
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; hready_ovr = 1'b1; HWRITE = 1'b0; HWDATA = 32'hFFFF_FFFF;
      @(negedge HCLK);
      n_checks++; if (reg_wr !== 8'h00) begin n_fail++; $display("FAIL ignored_pulse_%0d got=%b exp=0", k, reg_wr); end
      @(posedge HCLK); #1;
      @(negedge HCLK);
      n_checks++; if (reg_wr !== 8'h00 || reg_q !== m_flat()) begin n_fail++; $display("FAIL ignored_regs_%0d got=%b/%h exp=0/%h", k, reg_wr, reg_q, m_flat()); end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, wd, rd, exp_rd;
    logic [1:0]  rf, rl, exp_resp;
    int          size, w, exp_w;
    bit          wr, lg;
    for (int n = 0; n < 80; n++) begin
      addr = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3)) | ($urandom_range(0, 3) << 12);
      size = $urandom_range(0, 3);
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      lg   = m_legal(addr, size);
      exp_w    = (ERR_EN && !lg) ? 1 : 0;
      exp_resp = (ERR_EN && !lg) ? 2'b01 : 2'b00;
      exp_rd   = m_apply(wr, addr, size, wd);
      xfer(wr, addr, 3'(size), wd, rd, w, rf, rl);
      n_checks++; if (w !== exp_w || rf !== exp_resp || rl !== exp_resp) begin n_fail++; $display("FAIL rand_resp_%0d addr=%h size=%0d got=%0d/%b/%b exp=%0d/%b/%b", n, addr, size, w, rf, rl, exp_w, exp_resp, exp_resp); end
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_rdata_%0d addr=%h size=%0d got=%h exp=%h", n, addr, size, rd, exp_rd); end
      n_checks++; if (reg_q !== m_flat()) begin n_fail++; $display("FAIL rand_regs_%0d got=%h exp=%h", n, reg_q, m_flat()); end
    end
  endtask

  task automatic test_reset_during_write();
    logic [31:0] rd;
    logic [1:0]  rf, rl;
    int          w;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h004; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h1234_5678;
    #2; HRESETn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    n_checks++; if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin n_fail++; $display("FAIL rst_async_resp got=%b/%b exp=1/00", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_checks++; if (reg_q[63:32] !== 32'h0 || reg_wr !== 8'h00) begin n_fail++; $display("FAIL rst_discard got=%h/%b exp=0/0", reg_q[63:32], reg_wr); end
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h004, 3'b010, 32'h0, rd, w, rf, rl);
    n_checks++; if (rd !== 32'h0 || w !== 0 || rl !== 2'b00) begin n_fail++; $display("FAIL rst_readback got=%h/%0d/%b exp=0/0/00", rd, w, rl); end
    n_checks++; if (reg_q !== m_flat()) begin n_fail++; $display("FAIL rst_regs got=%h exp=%h", reg_q, m_flat()); end
  endtask

  task automatic test_pulse_counts();
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (pulse_cnt[i] !== exp_pulses[i]) begin n_fail++; $display("FAIL pulse_count_%0d got=%0d exp=%0d", i, pulse_cnt[i], exp_pulses[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin model[i] = 32'h0; exp_pulses[i] = 0; pulse_cnt[i] = 0; end
    HRESETn = 1'b0; HSEL = 1'b0; hready_ovr = 1'b1; HTRANS = 2'b00; HSIZE = 3'b010;
    HWRITE = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1; HRESETn = 1'b1;
    test_reset();
    test_back_to_back();
    test_lanes();
    test_errors();
    test_ignored();
    test_random();
    test_reset_during_write();
    test_pulse_counts();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
